ext_pipe_stage: RTL and testbench

Registered, parametrised immediate/offset extension stage between ID and EX.
- Covers every extension mode of the current MIPS datapath: sign, zero, lui, shamt, branch offset, jump target and relative jump.
- Adds a valid/ready handshake, a one-entry skid buffer and a flush.
- Sits on the ID→EX boundary, so stalls and branch squashes apply to extended operands without separate extension logic.

---
 rtl/ext_pipe_stage_if.sv | 28 ++
 rtl/ext_pipe_stage.sv | 113 +++++++++++
 tb/tb_ext_pipe_stage.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_pipe_stage_if.sv
// ID->EX extension stage bus: upstream entry fields plus downstream valid/ready result.
interface ext_pipe_stage_if #(
    parameter int DW = 32,
    parameter int IW = 16,
    parameter int JW = 26
) ();
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_mode;
    logic [IW-1:0] in_imm;
    logic [JW-1:0] in_jidx;
    logic [DW-1:0] in_pc4;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_err;

    // master drives instruction fields and downstream ready; slave is the stage itself
    modport master (
        output in_valid, in_mode, in_imm, in_jidx, in_pc4, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_imm, in_jidx, in_pc4, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_pipe_stage.sv
// Registered immediate/offset extension between ID and EX, with a one-entry skid buffer
// so in_ready is a pure register output, plus flush for branch squashes.
module ext_pipe_stage #(
    parameter int DW = 32,
    parameter int IW = 16,
    parameter int JW = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ext_pipe_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        M_SEXT  = 3'd0,
        M_ZEXT  = 3'd1,
        M_LUI   = 3'd2,
        M_SHAMT = 3'd3,
        M_BROFF = 3'd4,
        M_JABS  = 3'd5,
        M_JREL  = 3'd6,
        M_RSVD  = 3'd7
    } mode_e;

    // Keeps the PC region bits above the word-aligned jump index
    localparam logic [DW-1:0] JABS_MASK = {{(DW-JW-2){1'b1}}, {(JW+2){1'b0}}};

    // Returns {err, data}
    function automatic logic [DW:0] ext_f(
        input logic [2:0]    mode,
        input logic [IW-1:0] imm,
        input logic [JW-1:0] jidx,
        input logic [DW-1:0] pc4
    );
        logic signed [DW-1:0] s_imm;
        logic signed [DW-1:0] s_jidx;
        logic [DW-1:0]        d;
        logic                 e;
        s_imm  = {{(DW-IW){imm[IW-1]}}, imm};
        s_jidx = {{(DW-JW){jidx[JW-1]}}, jidx};
        d      = '0;
        e      = 1'b0;
        case (mode_e'(mode))
            M_SEXT:  d = s_imm;
            M_ZEXT:  d = DW'(imm);
            M_LUI:   d = DW'(imm) << (DW-IW);
            M_SHAMT: d = DW'(imm[10:6]);
            M_BROFF: d = s_imm <<< 2;
            M_JABS:  d = (pc4 & JABS_MASK) | (DW'(jidx) << 2);
            M_JREL:  d = s_jidx <<< 2;
            default: begin
                d = '0;
                e = 1'b1;
            end
        endcase
        return {e, d};
    endfunction

    // p0: combinational extension of the incoming entry
    logic [DW-1:0] w_ext_data_p0;
    logic          w_ext_err_p0;
    logic          w_accept;
    logic          w_consume;

    logic          r_out_vld_p1;
    logic [DW-1:0] r_out_data_p1;
    logic          r_out_err_p1;
    logic          r_skid_vld_p1;
    logic [DW-1:0] r_skid_data_p1;
    logic          r_skid_err_p1;

    assign {w_ext_err_p0, w_ext_data_p0} = ext_f(bus.in_mode, bus.in_imm, bus.in_jidx, bus.in_pc4);

    assign w_accept  = bus.in_valid && !r_skid_vld_p1;
    assign w_consume = r_out_vld_p1 && bus.out_ready;

    // p1: output register and skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld_p1   <= 1'b0;
            r_out_data_p1  <= '0;
            r_out_err_p1   <= 1'b0;
            r_skid_vld_p1  <= 1'b0;
            r_skid_data_p1 <= '0;
            r_skid_err_p1  <= 1'b0;
        end else if (flush) begin
            r_out_vld_p1  <= 1'b0;
            r_out_err_p1  <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
        end else if (w_consume && r_skid_vld_p1) begin
            // in_ready is low here, so no accept can collide with the drain
            r_out_data_p1 <= r_skid_data_p1;
            r_out_err_p1  <= r_skid_err_p1;
            r_skid_vld_p1 <= 1'b0;
        end else if (w_accept && (!r_out_vld_p1 || w_consume)) begin
            r_out_vld_p1  <= 1'b1;
            r_out_data_p1 <= w_ext_data_p0;
            r_out_err_p1  <= w_ext_err_p0;
        end else if (w_accept) begin
            r_skid_vld_p1  <= 1'b1;
            r_skid_data_p1 <= w_ext_data_p0;
            r_skid_err_p1  <= w_ext_err_p0;
        end else if (w_consume) begin
            r_out_vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = !r_skid_vld_p1;
    assign bus.out_valid = r_out_vld_p1;
    assign bus.out_data  = r_out_data_p1;
    assign bus.out_err   = r_out_err_p1;

endmodule

// File: tb/tb_ext_pipe_stage.sv
// Scoreboard bench for ext_pipe_stage: directed mode vectors, backpressure, flush, async reset, random traffic.
module tb_ext_pipe_stage;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int JW = 26;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    ext_pipe_stage_if #(.DW(DW), .IW(IW), .JW(JW)) bus ();

    ext_pipe_stage #(.DW(DW), .IW(IW), .JW(JW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    logic [DW:0]   sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_err;
    bit            rnd_done = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: integer arithmetic on the raw fields, returns {err, data}
    function automatic logic [DW:0] model(input logic [2:0] m, input logic [15:0] imm,
                                          input logic [25:0] j, input logic [31:0] pc);
        int       si;
        int       sj;
        logic [31:0] d;
        logic     e;
        si = int'($signed(imm));
        sj = int'($signed(j));
        d  = 32'h0;
        e  = 1'b0;
        case (m)
            3'd0: d = si;
            3'd1: d = 32'(imm);
            3'd2: d = {imm, 16'h0000};
            3'd3: d = 32'(imm >> 6) & 32'h1F;
            3'd4: d = si * 4;
            3'd5: d = (pc & 32'hF000_0000) | (32'(j) << 2);
            3'd6: d = sj * 4;
            default: e = 1'b1;
        endcase
        return {e, d};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [2:0] m, input logic [IW-1:0] imm, input logic [JW-1:0] j,
                        input logic [DW-1:0] pc, input logic [DW:0] exp);
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_imm   = imm;
        bus.in_jidx  = j;
        bus.in_pc4   = pc;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(exp);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        errors++;
        checks++;
        $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_lat(input string name, input logic [2:0] m, input logic [IW-1:0] imm,
                            input logic [JW-1:0] j, input logic [DW-1:0] pc, input logic [DW:0] exp);
        send(m, imm, j, pc, exp);
        @(negedge clk);
        chk1({name, "_valid"}, bus.out_valid, 1'b1);
        chkd({name, "_data"}, bus.out_data, exp[DW-1:0]);
        chk1({name, "_err"}, bus.out_err, exp[DW]);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_err !== prev_err) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h e=%b required v=1 d=%h e=%b",
                             bus.out_valid, bus.out_data, bus.out_err, prev_data, prev_err);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got d=%h e=%b required no output", bus.out_data, bus.out_err);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_err, bus.out_data} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got e=%b d=%h required e=%b d=%h",
                                 bus.out_err, bus.out_data, e[DW], e[DW-1:0]);
                    end
                end
            end
        end
        prev_stall = !rst && !flush && bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_err   = bus.out_err;
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mode   = 3'd0;
        bus.in_imm    = '0;
        bus.in_jidx   = '0;
        bus.in_pc4    = '0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkd("rst_out_data", bus.out_data, '0);
        chk1("rst_out_err", bus.out_err, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Extension modes, one cycle after acceptance
        bus.out_ready = 1'b1;
        send_lat("sext",  3'd0, 16'h8004, '0, '0, {1'b0, 32'hFFFF8004});
        send_lat("zext",  3'd1, 16'h8004, '0, '0, {1'b0, 32'h00008004});
        send_lat("lui",   3'd2, 16'h8004, '0, '0, {1'b0, 32'h80040000});
        send_lat("broff", 3'd4, 16'h8004, '0, '0, {1'b0, 32'hFFFE0010});
        send_lat("shamt", 3'd3, 16'h0540, '0, '0, {1'b0, 32'h00000015});
        send_lat("jabs",  3'd5, 16'h0000, 26'h0000123, 32'h90000010, {1'b0, 32'h9000048C});
        send_lat("jrel",  3'd6, 16'h0000, 26'h3FFFFFF, '0, {1'b0, 32'hFFFFFFFC});
        send_lat("rsvd",  3'd7, 16'hFFFF, 26'h3FFFFFF, 32'hFFFFFFFF, {1'b1, 32'h00000000});

        // Backpressure: A to output, B to skid, C held upstream
        bus.out_ready = 1'b0;
        send(3'd0, 16'd1, '0, '0, {1'b0, 32'd1});
        send(3'd0, 16'd2, '0, '0, {1'b0, 32'd2});
        @(negedge clk);
        chk1("bp_in_ready_low", bus.in_ready, 1'b0);
        chkd("bp_hold_a", bus.out_data, 32'd1);
        fork
            send(3'd0, 16'd3, '0, '0, {1'b0, 32'd3});
            begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk1("bp_c_held", bus.in_ready, 1'b0);
                chkd("bp_hold_a2", bus.out_data, 32'd1);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
                @(negedge clk);
                chkd("bp_seq0", bus.out_data, 32'd1);
                @(negedge clk);
                chkd("bp_seq1", bus.out_data, 32'd2);
                chk1("bp_ready_back", bus.in_ready, 1'b1);
                @(negedge clk);
                chkd("bp_seq2", bus.out_data, 32'd3);
                chk1("bp_seq2_valid", bus.out_valid, 1'b1);
            end
        join
        @(posedge clk);
        #1;

        // Flush with both entries full and an input offered
        bus.out_ready = 1'b0;
        send(3'd7, 16'd5, '0, '0, {1'b1, 32'd0});
        send(3'd0, 16'd6, '0, '0, {1'b0, 32'd6});
        bus.in_valid = 1'b1;
        bus.in_mode  = 3'd0;
        bus.in_imm   = 16'd7;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk1("flush_out_valid", bus.out_valid, 1'b0);
        chk1("flush_in_ready", bus.in_ready, 1'b1);
        chk1("flush_out_err", bus.out_err, 1'b0);
        @(negedge clk);
        chk1("flush_no_input", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Flush discards an input accepted in the same cycle
        send(3'd0, 16'd9, '0, '0, {1'b0, 32'd9});
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'd10;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk1("flush_accept_dropped", bus.out_valid, 1'b0);
        @(negedge clk);
        chk1("flush_accept_dropped2", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a stall
        send(3'd0, 16'd8, '0, '0, {1'b0, 32'd8});
        send(3'd7, 16'd0, '0, '0, {1'b1, 32'd0});
        #1 rst = 1'b1;
        #1;
        chk1("arst_out_valid", bus.out_valid, 1'b0);
        chkd("arst_out_data", bus.out_data, '0);
        chk1("arst_out_err", bus.out_err, 1'b0);
        chk1("arst_in_ready", bus.in_ready, 1'b1);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send_lat("post_reset", 3'd1, 16'h00FF, '0, '0, {1'b0, 32'h000000FF});

        // Random valid/ready traffic against the reference model
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    logic [2:0]    m;
                    logic [IW-1:0] imm;
                    logic [JW-1:0] j;
                    logic [DW-1:0] pc;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    m   = 3'($urandom_range(0, 7));
                    imm = IW'($urandom);
                    j   = JW'($urandom);
                    pc  = $urandom;
                    send(m, imm, j, pc, model(m, imm, j, pc));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2000 && (sb.size() != 0 || bus.out_valid); k++) @(posedge clk);
        @(negedge clk);
        chkd("drain_empty", DW'(sb.size()), '0);
        chk1("drain_out_valid", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
